stream_window_sum: RTL and testbench
====================================

// Module: stream_window_sum
// PURPOSE
//  Downstream consumer for a zip_add-style valid/ready stream. Sums each group of
//  WINDOW consecutive input elements and emits one registered sum per group.
//  Supports backpressure in both directions and an optional flush that emits a
//  partial group early. One registered output slot; sustains 1 element/cycle.
// PARAMETERS
//  N       8  input element width (two's complement)
//  OUT_W   8  output sum width; sum wraps modulo 2^OUT_W (OUT_W >= N)
//  WINDOW  4  elements per group (>= 1)
//  LEN_W   3  width of sOut_len = $clog2(WINDOW+1)
// PORTS
//  clk          in   1      clock, all state updates on posedge
//  nrst         in   1      reset, asynchronous assert, active-low
//  sIn          in   N      input element
//  sIn_valid    in   1      sIn holds a valid element
//  sIn_ready    out  1      block accepts sIn this cycle
//  flush        in   1      request to emit the current partial group
//  flush_ready  out  1      flush is taken this cycle (same as sIn_ready)
//  sOut         out  OUT_W  group sum
//  sOut_len     out  LEN_W  number of elements summed into sOut
//  sOut_valid   out  1      sOut/sOut_len valid
//  sOut_ready   in   1      downstream accepts sOut this cycle
// BEHAVIOUR
//  - Reset (nrst=0, async): acc=0, cnt=0, sOut=0, sOut_len=0, sOut_valid=0.
//    Any partial group is discarded. Outputs stay 0 until the first emit.
//  - slot_free = !sOut_valid || sOut_ready. sIn_ready = flush_ready = slot_free.
//    Both are combinational from sOut_valid/sOut_ready only, never from sIn_valid.
//  - In-handshake (in_hs) = sIn_valid && sIn_ready. Out-handshake = sOut_valid && sOut_ready.
//  - Addend ext = sign-extend(sIn) to OUT_W. next_acc = acc + ext (mod 2^OUT_W).
//  - State is acc/cnt; cnt counts 0..WINDOW-1 elements held.
//  - Cycle with in_hs and cnt==WINDOW-1: sOut<=next_acc, sOut_len<=WINDOW,
//    sOut_valid<=1, acc<=0, cnt<=0. Latency: sum visible the cycle after the last in_hs.
//  - Cycle with in_hs and cnt<WINDOW-1 and !flush: acc<=next_acc, cnt<=cnt+1.
//  - flush && slot_free: emit (in_hs ? next_acc : acc) with len=cnt+in_hs, then clear acc/cnt.
//    If that len==0, nothing is emitted and no state changes.
//    flush while !slot_free is ignored; the requester holds flush until flush_ready.
//  - Out-handshake with no new emit in the same cycle: sOut_valid<=0. sOut/sOut_len keep their value.
//  - Out-handshake and new emit in the same cycle: the slot is reloaded and sOut_valid stays 1.
//    This gives full throughput (WINDOW=1 gives 1 sum/cycle).
//  - sOut_valid=1 && !sOut_ready: sOut, sOut_len, sOut_valid are held stable.
//    sIn_ready=0, so no element is lost or double counted.
//  - sIn_valid=0 never changes acc/cnt. Bubbles between elements are allowed.
// TESTING
//  1. WINDOW=4, sIn=1,2,3,4 back-to-back, sOut_ready=1 -> sOut=10, len=4, valid for exactly 1 cycle,
//     1 cycle after the 4th in_hs.
//  2. Same as 1 with sOut_ready=0 for 5 cycles after emit -> sOut=10 held, sIn_ready=0.
//     Then sIn=5..8 after release -> sOut=26.
//  3. Wrap/sign: sIn=100 x4 -> sOut=144 (400 mod 256). sIn=8'hFF x4 -> sOut=8'hFC.
//  4. Flush: sIn=5,6 then flush -> sOut=11, len=2. Flush with cnt=0 and no in_hs -> no sOut_valid.
//     flush + in_hs(7) with cnt=1 (acc=3) -> sOut=10, len=2.
//  5. Reset mid-group: sIn=9,9, pulse nrst low -> all outputs 0 immediately.
//     Then sIn=1,2,3,4 -> sOut=10 (old 18 discarded).
//  6. WINDOW=1, sIn=0..9 every cycle, sOut_ready=1 -> sOut=0..9 on consecutive cycles, sIn_ready stays 1.

Source files
------------

// File: rtl/stream_window_sum.sv
// stream_window_sum: accumulates groups of WINDOW signed elements from a
// valid/ready stream and emits one registered sum per group.  A flush request
// emits the current partial group early.  A single output slot is reloaded in
// the same cycle it drains, so one element per cycle is sustained.
module stream_window_sum #(
  parameter int N      = 8,
  parameter int OUT_W  = 8,
  parameter int WINDOW = 4,
  parameter int LEN_W  = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [N-1:0]     sIn,
  input  logic             sIn_valid,
  output logic             sIn_ready,
  input  logic             flush,
  output logic             flush_ready,
  output logic [OUT_W-1:0] sOut,
  output logic [LEN_W-1:0] sOut_len,
  output logic             sOut_valid,
  input  logic             sOut_ready
);

  localparam logic [LEN_W-1:0] LAST_CNT = LEN_W'(WINDOW - 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WINDOW);

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] sout_q, sout_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             valid_q, valid_d;

  logic             slot_free;
  logic             in_hs;
  logic             emit;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] next_acc;
  logic [LEN_W-1:0] flush_len;

  // Ready depends only on the output slot, never on sIn_valid.
  assign slot_free   = !valid_q || sOut_ready;
  assign sIn_ready   = slot_free;
  assign flush_ready = slot_free;
  assign in_hs       = sIn_valid && slot_free;

  assign ext       = OUT_W'($signed(sIn));
  assign next_acc  = acc_q + ext;
  assign flush_len = cnt_q + LEN_W'(in_hs);

  // Next-state: accumulate, complete a group, or flush a partial one.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    len_d   = len_q;
    valid_d = valid_q;
    emit    = 1'b0;
    if (flush && slot_free) begin
      // An empty flush is a no-op; the element (if any) joins the flushed group.
      if (flush_len != '0) begin
        emit   = 1'b1;
        sout_d = in_hs ? next_acc : acc_q;
        len_d  = flush_len;
        acc_d  = '0;
        cnt_d  = '0;
      end
    end else if (in_hs) begin
      if (cnt_q == LAST_CNT) begin
        emit   = 1'b1;
        sout_d = next_acc;
        len_d  = FULL_LEN;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = next_acc;
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A reload in the drain cycle keeps valid high for back-to-back sums.
    if (emit) begin
      valid_d = 1'b1;
    end else if (sOut_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output-slot registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      sout_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      len_q   <= len_d;
      valid_q <= valid_d;
    end
  end

  assign sOut       = sout_q;
  assign sOut_len   = len_q;
  assign sOut_valid = valid_q;

endmodule

// File: tb/tb_stream_window_sum.sv
// Bench for stream_window_sum: two instances (WINDOW=4 and WINDOW=1) share the
// same stimulus and are compared each cycle against a queue-based group model.
module tb_stream_window_sum;

  logic       clk;
  logic       nrst;
  logic [7:0] sIn;
  logic       sIn_valid;
  logic       flush;
  logic       sOut_ready;

  logic       rdy_a, frdy_a, vld_a;
  logic [7:0] out_a;
  logic [2:0] len_a;
  logic       rdy_b, frdy_b, vld_b;
  logic [7:0] out_b;
  logic [0:0] len_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state, index 0 = WINDOW 4, index 1 = WINDOW 1.
  int grp [2][$];
  int m_sum [2];
  int m_len [2];
  bit m_valid [2];
  int win [2] = '{4, 1};

  stream_window_sum #(.N(8), .OUT_W(8), .WINDOW(4), .LEN_W(3)) u_w4 (
    .clk(clk), .nrst(nrst), .sIn(sIn), .sIn_valid(sIn_valid), .sIn_ready(rdy_a),
    .flush(flush), .flush_ready(frdy_a), .sOut(out_a), .sOut_len(len_a),
    .sOut_valid(vld_a), .sOut_ready(sOut_ready)
  );

  stream_window_sum #(.N(8), .OUT_W(8), .WINDOW(1), .LEN_W(1)) u_w1 (
    .clk(clk), .nrst(nrst), .sIn(sIn), .sIn_valid(sIn_valid), .sIn_ready(rdy_b),
    .flush(flush), .flush_ready(frdy_b), .sOut(out_b), .sOut_len(len_b),
    .sOut_valid(vld_b), .sOut_ready(sOut_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int grp_sum(input int k);
    int s = 0;
    foreach (grp[k][i]) s += grp[k][i];
    return s & 255;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      grp[k].delete();
      m_sum[k]   = 0;
      m_len[k]   = 0;
      m_valid[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] d, input bit f, input bit r);
    for (int k = 0; k < 2; k++) begin
      bit free, hs, emit;
      free = !m_valid[k] || r;
      hs   = v && free;
      emit = 1'b0;
      if (free && f) begin
        if (hs) grp[k].push_back(int'($signed(d)));
        if (grp[k].size() > 0) begin
          m_sum[k] = grp_sum(k);
          m_len[k] = grp[k].size();
          grp[k].delete();
          emit = 1'b1;
        end
      end else if (hs) begin
        grp[k].push_back(int'($signed(d)));
        if (grp[k].size() == win[k]) begin
          m_sum[k] = grp_sum(k);
          m_len[k] = win[k];
          grp[k].delete();
          emit = 1'b1;
        end
      end
      if (emit) m_valid[k] = 1'b1;
      else if (r) m_valid[k] = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    check_eq("a_valid", vld_a, m_valid[0]);
    check_eq("a_sum",   out_a, m_sum[0]);
    check_eq("a_len",   len_a, m_len[0]);
    check_eq("b_valid", vld_b, m_valid[1]);
    check_eq("b_sum",   out_b, m_sum[1]);
    check_eq("b_len",   len_b, m_len[1]);
  endtask

  // Drive one cycle: inputs change after the falling edge, ready is checked
  // before the rising edge, registered outputs after the next falling edge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit f, input bit r);
    sIn_valid  = v;
    sIn        = d;
    flush      = f;
    sOut_ready = r;
    #1;
    check_eq("a_ready", rdy_a, !m_valid[0] || r);
    check_eq("a_fready", frdy_a, !m_valid[0] || r);
    check_eq("b_ready", rdy_b, !m_valid[1] || r);
    @(posedge clk);
    model_step(v, d, f, r);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_a_valid", vld_a, 0);
    check_eq("rst_a_sum",   out_a, 0);
    check_eq("rst_a_len",   len_a, 0);
    check_eq("rst_b_valid", vld_b, 0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    nrst = 1'b1; sIn = '0; sIn_valid = 1'b0; flush = 1'b0; sOut_ready = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Basic group of four.
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 1);
    check_eq("t1_sum", out_a, 10);
    check_eq("t1_len", len_a, 4);
    check_eq("t1_valid", vld_a, 1);
    cycle(0, 0, 0, 1);
    check_eq("t1_one_cycle", vld_a, 0);

    // Backpressure held for five cycles with an element offered.
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 8'd5, 0, 0);
      check_eq("t2_hold", out_a, 10);
    end
    for (int i = 5; i <= 8; i++) cycle(1, 8'(i), 0, 1);
    check_eq("t2_sum", out_a, 26);

    // Wrap and sign extension.
    for (int i = 0; i < 4; i++) cycle(1, 8'd100, 0, 1);
    check_eq("t3_wrap", out_a, 144);
    for (int i = 0; i < 4; i++) cycle(1, 8'hFF, 0, 1);
    check_eq("t3_neg", out_a, 8'hFC);

    // Flush of a partial group, empty flush, flush with a same-cycle element.
    cycle(1, 8'd5, 0, 1);
    cycle(1, 8'd6, 0, 1);
    cycle(0, 0, 1, 1);
    check_eq("t4_flush_sum", out_a, 11);
    check_eq("t4_flush_len", len_a, 2);
    cycle(0, 0, 1, 1);
    check_eq("t4_empty_flush", vld_a, 0);
    cycle(1, 8'd3, 0, 1);
    cycle(1, 8'd7, 1, 1);
    check_eq("t4_hs_flush_sum", out_a, 10);
    check_eq("t4_hs_flush_len", len_a, 2);

    // Reset mid-group discards the partial sum.
    cycle(0, 0, 0, 1);
    cycle(1, 8'd9, 0, 1);
    cycle(1, 8'd9, 0, 1);
    sIn_valid = 1'b0;
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 1);
    check_eq("t5_sum", out_a, 10);

    // WINDOW=1 instance at full rate.
    for (int i = 0; i < 10; i++) begin
      cycle(1, 8'(i), 0, 1);
      check_eq("t6_sum", out_b, i);
      check_eq("t6_valid", vld_b, 1);
    end
    cycle(0, 0, 0, 1);

    // Randomized traffic with bubbles, backpressure and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
